// File: rtl/apb_slave_regs_if.sv
// apb_slave_regs_if: APB bus between requester and the register completer.
// PSTRB exists only when APB_SLV_PSTRB_EN is defined.
interface apb_slave_regs_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
`ifdef APB_SLV_PSTRB_EN
  logic [3:0]  PSTRB;
  modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, input PRDATA, PREADY, PSLVERR);
  modport slave  (input PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, output PRDATA, PREADY, PSLVERR);
`else
  modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA, input PRDATA, PREADY, PSLVERR);
  modport slave  (input PSEL, PENABLE, PWRITE, PADDR, PWDATA, output PRDATA, PREADY, PSLVERR);
`endif
endinterface

// File: rtl/apb_slave_regs.sv
// apb_slave_regs: APB completer over NREGS word registers with WAIT_STATES wait cycles and
// PSLVERR on out-of-range indices; APB_SLV_PSTRB_EN enables per-byte write strobes.
module apb_slave_regs #(
  parameter int          NREGS       = 8,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  apb_slave_regs_if.slave    bus,
  output logic [32*NREGS-1:0] regs_o
);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  idx_q;
  logic        wr_q;
  logic [31:0] wdata_q;
  logic [3:0]  strb_q;
  logic [31:0] regs_q [NREGS];
  logic [31:0] rdata;
  logic        setup, ready, in_range, commit;
  logic        unused_addr;
  assign unused_addr = ^{bus.PADDR[31:10], bus.PADDR[1:0]};
  assign setup    = state_q == IDLE && bus.PSEL && !bus.PENABLE;
  assign ready    = state_q == ACCESS && cnt_q == 4'd0;
  assign in_range = {1'b0, idx_q} < 9'(NREGS);
  assign commit   = ready && bus.PSEL && bus.PENABLE;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (setup) begin
      state_d = ACCESS;
      cnt_d   = 4'(WAIT_STATES);
    end else if (state_q == ACCESS) begin
      state_d = (!bus.PSEL || commit) ? IDLE : ACCESS;
      cnt_d   = (bus.PSEL && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
    end
  end
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (setup) begin
        idx_q   <= bus.PADDR[9:2];
        wr_q    <= bus.PWRITE;
        wdata_q <= bus.PWDATA;
`ifdef APB_SLV_PSTRB_EN
        strb_q  <= bus.PSTRB;
`else
        strb_q  <= 4'hF;
`endif
      end
    end
  end
  // Register 0 holds ID_VALUE from reset and is never a write target.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= (i == 0) ? ID_VALUE : 32'd0;
    end else if (commit && wr_q) begin
      for (int i = 1; i < NREGS; i++)
        for (int b = 0; b < 4; b++)
          if (idx_q == 8'(i) && strb_q[b]) regs_q[i][8*b +: 8] <= wdata_q[8*b +: 8];
    end
  end
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NREGS; i++) rdata = (idx_q == 8'(i)) ? regs_q[i] : rdata;
  end
  assign bus.PRDATA  = (ready && !wr_q) ? rdata : '0;
  assign bus.PREADY  = ready;
  assign bus.PSLVERR = ready && !in_range;
  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign regs_o[32*g +: 32] = regs_q[g];
  end
endmodule
